// File: rtl/jmp_pc_unit.sv
// rtl/jmp_pc_unit.sv - jump condition evaluation, program counter and return-address stack
module jmp_pc_unit #(
    parameter int ADDR_W      = 15,
    parameter int STACK_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [2:0]                       cmd_j,
    input  logic                             alu_zr,
    input  logic                             alu_ng,
    input  logic [ADDR_W-1:0]                jmp_addr,
    input  logic                             call,
    input  logic                             ret,
    input  logic                             err_clr,
    output logic [ADDR_W-1:0]                pc_out,
    output logic                             taken,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             err_ovf,
    output logic                             err_unf
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_d;
    logic [SP_W-1:0]   sp_d;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;
    logic              cond;
    logic              push;
    logic              ovf_set;
    logic              unf_set;
    logic              taken_c;

    assign pc_next     = pc_out + ADDR_W'(1);
    assign stack_full  = (sp == SP_MAX);
    assign stack_empty = (sp == '0);
    assign top_idx     = IDX_W'(sp - SP_W'(1));
    assign push_idx    = IDX_W'(sp);

    always_comb begin
        cond = 1'b0;
        case (cmd_j)
            3'b000: cond = 1'b0;
            3'b001: cond = !alu_ng && !alu_zr;
            3'b010: cond = alu_zr;
            3'b011: cond = !alu_ng || alu_zr;
            3'b100: cond = alu_ng;
            3'b101: cond = !alu_zr;
            3'b110: cond = alu_ng || alu_zr;
            3'b111: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // Return has priority over any jump or call presented in the same cycle.
    always_comb begin
        pc_d    = pc_next;
        sp_d    = sp;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        taken_c = 1'b0;
        if (!en) begin
            pc_d = pc_out;
        end else if (ret) begin
            if (!stack_empty) begin
                pc_d    = stack_mem[top_idx];
                sp_d    = sp - SP_W'(1);
                taken_c = 1'b1;
            end else begin
                unf_set = 1'b1;
            end
        end else if (cond) begin
            pc_d    = jmp_addr;
            taken_c = 1'b1;
            if (call) begin
                if (!stack_full) begin
                    push = 1'b1;
                    sp_d = sp + SP_W'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
    end

    assign taken = taken_c && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out  <= '0;
            sp      <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            pc_out <= pc_d;
            sp     <= sp_d;
            if (ovf_set)
                err_ovf <= 1'b1;
            else if (err_clr)
                err_ovf <= 1'b0;
            if (unf_set)
                err_unf <= 1'b1;
            else if (err_clr)
                err_unf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            stack_mem[push_idx] <= pc_next;
    end
endmodule

// File: tb/tb_jmp_pc_unit.sv
// tb/tb_jmp_pc_unit.sv - directed self-checking bench for jmp_pc_unit
module tb_jmp_pc_unit;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [2:0]        cmd_j = '0;
    logic              alu_zr = 1'b0;
    logic              alu_ng = 1'b0;
    logic [ADDR_W-1:0] jmp_addr = '0;
    logic              call = 1'b0;
    logic              ret = 1'b0;
    logic              err_clr = 1'b0;
    logic [ADDR_W-1:0] pc_out;
    logic              taken;
    logic [3:0]        sp;
    logic              stack_full;
    logic              stack_empty;
    logic              err_ovf;
    logic              err_unf;

    int errors = 0;
    int checks = 0;

    jmp_pc_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .cmd_j(cmd_j), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .jmp_addr(jmp_addr), .call(call), .ret(ret), .err_clr(err_clr),
        .pc_out(pc_out), .taken(taken), .sp(sp), .stack_full(stack_full),
        .stack_empty(stack_empty), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] cmd;
        logic       zr;
        logic       ng;
        logic       exp_taken;
    } vec_t;

    vec_t vecs[24];
    // Expected outcome per cmd_j, bits {zero, negative, positive}.
    logic [2:0] exp_bits [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [2:0] c, input logic [ADDR_W-1:0] a,
                         input logic ca, input logic r, input logic clr);
        en = e; cmd_j = c; jmp_addr = a; call = ca; ret = r; err_clr = clr;
        alu_zr = 1'b0; alu_ng = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [ADDR_W-1:0] a);
        drive(1'b1, 3'b111, a, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b000, '0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [ADDR_W-1:0] pushed[$];
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] exp_pc;

    initial begin
        exp_bits[0] = 3'b000; exp_bits[1] = 3'b001; exp_bits[2] = 3'b100; exp_bits[3] = 3'b101;
        exp_bits[4] = 3'b010; exp_bits[5] = 3'b011; exp_bits[6] = 3'b110; exp_bits[7] = 3'b111;
        for (int c = 0; c < 8; c++) begin
            vecs[c*3+0] = '{cmd: 3'(c), zr: 1'b0, ng: 1'b0, exp_taken: exp_bits[c][0]};
            vecs[c*3+1] = '{cmd: 3'(c), zr: 1'b0, ng: 1'b1, exp_taken: exp_bits[c][1]};
            vecs[c*3+2] = '{cmd: 3'(c), zr: 1'b1, ng: 1'b0, exp_taken: exp_bits[c][2]};
        end

        // reset state, with an always-jump presented to confirm taken is masked
        drive(1'b1, 3'b111, 15'h0123, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst_pc", 32'(pc_out), 0);
        check("rst_taken", 32'(taken), 0);
        check("rst_empty", 32'(stack_empty), 1);
        check("rst_full", 32'(stack_full), 0);
        check("rst_sp", 32'(sp), 0);
        check("rst_errs", 32'({err_ovf, err_unf}), 0);
        tick();
        rst = 1'b0;
        tick();
        check("jump_0123", 32'(pc_out), 32'h0123);
        drive(1'b1, 3'b000, '0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc", 32'(pc_out), 0);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            check("inc_taken", 32'(taken), 0);
            tick();
        end
        check("inc_pc5", 32'(pc_out), 5);

        // condition table
        for (int i = 0; i < 24; i++) begin
            set_pc(15'h0100 + 15'(i));
            cmd_j = vecs[i].cmd; alu_zr = vecs[i].zr; alu_ng = vecs[i].ng; jmp_addr = 15'h1000;
            #1;
            check($sformatf("cond_taken_%0d", i), 32'(taken), 32'(vecs[i].exp_taken));
            exp_pc = vecs[i].exp_taken ? 15'h1000 : 15'h0101 + 15'(i);
            tick();
            check($sformatf("cond_pc_%0d", i), 32'(pc_out), 32'(exp_pc));
        end

        // call / return
        set_pc(15'h0010);
        drive(1'b1, 3'b111, 15'h0200, 1'b1, 1'b0, 1'b0);
        #1;
        check("call_taken", 32'(taken), 1);
        tick();
        check("call_pc", 32'(pc_out), 32'h0200);
        check("call_sp", 32'(sp), 1);
        drive(1'b1, 3'b000, '0, 1'b0, 1'b0, 1'b0);
        tick();
        check("call_inc", 32'(pc_out), 32'h0201);
        drive(1'b1, 3'b000, '0, 1'b0, 1'b1, 1'b0);
        #1;
        check("ret_taken", 32'(taken), 1);
        tick();
        check("ret_pc", 32'(pc_out), 32'h0011);
        check("ret_sp", 32'(sp), 0);
        check("ret_empty", 32'(stack_empty), 1);

        // nine nested calls: the ninth overflows but still jumps
        cur = 15'h0011;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) pushed.push_back(cur + 15'd1);
            drive(1'b1, 3'b111, 15'h2000 + 15'(i * 16'h0100), 1'b1, 1'b0, 1'b0);
            #1;
            check($sformatf("ncall_taken_%0d", i), 32'(taken), 1);
            cur = jmp_addr;
            tick();
            check($sformatf("ncall_pc_%0d", i), 32'(pc_out), 32'(cur));
            check($sformatf("ncall_ovf_%0d", i), 32'(err_ovf), (i == 8) ? 1 : 0);
        end
        check("ovf_sp", 32'(sp), 8);
        check("ovf_full", 32'(stack_full), 1);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'b000, '0, 1'b0, 1'b1, 1'b0);
            tick();
            cur = pushed.pop_back();
            check($sformatf("pop_pc_%0d", k), 32'(pc_out), 32'(cur));
        end
        check("pop_sp", 32'(sp), 0);
        drive(1'b1, 3'b000, '0, 1'b0, 1'b1, 1'b0);
        #1;
        check("unf_taken", 32'(taken), 0);
        tick();
        check("unf_pc", 32'(pc_out), 32'(cur + 15'd1));
        check("unf_flag", 32'(err_unf), 1);
        check("unf_sp", 32'(sp), 0);
        // set wins over clear in the same cycle
        drive(1'b1, 3'b000, '0, 1'b0, 1'b1, 1'b1);
        tick();
        check("set_wins_unf", 32'(err_unf), 1);
        check("clr_ovf", 32'(err_ovf), 0);
        drive(1'b1, 3'b000, '0, 1'b0, 1'b0, 1'b1);
        tick();
        check("clr_flags", 32'({err_ovf, err_unf}), 0);

        // stall
        set_pc(15'h0300);
        drive(1'b0, 3'b111, 15'h0555, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_taken", 32'(taken), 0);
            tick();
            check("stall_pc", 32'(pc_out), 32'h0300);
            check("stall_sp", 32'(sp), 0);
        end
        // pop wins over a simultaneous call
        drive(1'b1, 3'b111, 15'h0400, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b111, 15'h0777, 1'b1, 1'b1, 1'b0);
        tick();
        check("prio_pc", 32'(pc_out), 32'h0301);
        check("prio_sp", 32'(sp), 0);

        // wrap
        set_pc(15'h7FFF);
        tick();
        check("wrap_pc", 32'(pc_out), 0);
        set_pc(15'h7FFF);
        drive(1'b1, 3'b111, 15'h0050, 1'b1, 1'b0, 1'b0);
        tick();
        check("wrap_call_sp", 32'(sp), 1);
        drive(1'b1, 3'b000, '0, 1'b0, 1'b1, 1'b0);
        tick();
        check("wrap_ret_pc", 32'(pc_out), 0);
        check("wrap_ret_sp", 32'(sp), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
